// File: rtl/lcd_row_arbiter.sv
// lcd_row_arbiter
// Shares a 2x16 character LCD between N_REQ text producers. Requests are
// served round-robin; each granted message stays on the display for at least
// HOLD_CYCLES clocks (the dwell), and the dwell timer can be frozen.
//
// Handshake: req[i] is a level. A grant happens on a rising edge where the
// arbiter is free (IDLE, or HOLD at dwell end with freeze low) and req is
// non-zero; on that edge the winner's text is latched and ack[w] pulses high
// for exactly one cycle. There is no ready/back-pressure: a producer must keep
// req high until it sees its ack bit, and its text is sampled only on that
// grant edge.
module lcd_row_arbiter #(
    parameter int unsigned   N_REQ       = 4,
    parameter int unsigned   HOLD_CYCLES = 70_000_000,
    parameter logic [127:0]  IDLE_A      = "  LCD  IDLE     ",
    parameter logic [127:0]  IDLE_B      = "  no requests   ",
    localparam int unsigned  PW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*128-1:0]   row_a_in,
    input  logic [N_REQ*128-1:0]   row_b_in,
    input  logic                   freeze,
    output logic [N_REQ-1:0]       ack,
    output logic [127:0]           row_A,
    output logic [127:0]           row_B,
    output logic [PW-1:0]          owner,
    output logic                   busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Last timer value of a dwell; reaching it with freeze low ends the dwell.
    localparam logic [31:0] DWELL_LAST = 32'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [31:0]       timer_q, timer_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [127:0]      row_a_q, row_a_d;
    logic [127:0]      row_b_q, row_b_d;
    logic              busy_q, busy_d;

    // Arbiter results
    logic              any_req;
    logic [PW-1:0]     win;
    logic [PW-1:0]     win_next;
    logic [127:0]      win_row_a;
    logic [127:0]      win_row_b;
    logic              dwell_end;
    logic              grant;

    assign any_req = |req;

    // Round-robin pick: first requester at or after rr_ptr, wrapping mod N_REQ.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        win   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            idx = PW'((int'(rr_ptr_q) + k) % int'(N_REQ));
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Pointer after the winner, wrapping at N_REQ (which need not be 2^PW).
    always_comb begin
        win_next = '0;
        if (int'(win) != int'(N_REQ) - 1) begin
            win_next = win + PW'(1);
        end
    end

    // Mux the winner's text slices out of the flattened input buses.
    always_comb begin
        win_row_a = '0;
        win_row_b = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win == PW'(i)) begin
                win_row_a = row_a_in[i*128 +: 128];
                win_row_b = row_b_in[i*128 +: 128];
            end
        end
    end

    // A dwell ends only when the timer is at its last value and not frozen;
    // a freeze landing exactly on that value parks the timer there.
    assign dwell_end = (state_q == ST_HOLD) && !freeze && (timer_q == DWELL_LAST);

    // Grant from IDLE, or re-grant at dwell end with no gap cycle.
    assign grant = any_req && ((state_q == ST_IDLE) || dwell_end);

    // Next-state and next-output logic for the IDLE/HOLD controller.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        ack_d    = '0;
        row_a_d  = row_a_q;
        row_b_d  = row_b_q;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_HOLD: begin
                if (!freeze) begin
                    if (timer_q != DWELL_LAST) begin
                        timer_d = timer_q + 32'd1;
                    end else if (!any_req) begin
                        // Dwell over with nobody waiting: last text stays up.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (grant) begin
            state_d    = ST_HOLD;
            busy_d     = 1'b1;
            timer_d    = '0;
            owner_d    = win;
            rr_ptr_d   = win_next;
            row_a_d    = win_row_a;
            row_b_d    = win_row_b;
            ack_d[win] = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            rr_ptr_q <= '0;
            owner_q  <= PW'(N_REQ - 1);
            ack_q    <= '0;
            row_a_q  <= IDLE_A;
            row_b_q  <= IDLE_B;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            ack_q    <= ack_d;
            row_a_q  <= row_a_d;
            row_b_q  <= row_b_d;
            busy_q   <= busy_d;
        end
    end

    assign ack   = ack_q;
    assign row_A = row_a_q;
    assign row_B = row_b_q;
    assign owner = owner_q;
    assign busy  = busy_q;

    // At most one producer is acknowledged per cycle.
    a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(ack));

    // busy mirrors the HOLD state.
    a_busy_state: assert property (@(posedge clk) disable iff (!reset_n) busy == (state_q == ST_HOLD));

endmodule

// File: tb/tb_lcd_row_arbiter.sv
// Bench for lcd_row_arbiter: directed scenarios plus randomized traffic, all
// compared against a cycle-level behavioural model of the sharing rules.
module tb_lcd_row_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam logic [127:0] IDLE_A = "  LCD  IDLE     ";
    localparam logic [127:0] IDLE_B = "  no requests   ";

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N-1:0]       req;
    logic [N*128-1:0]   row_a_in;
    logic [N*128-1:0]   row_b_in;
    logic               freeze;
    logic [N-1:0]       ack;
    logic [127:0]       row_A;
    logic [127:0]       row_B;
    logic [1:0]         owner;
    logic               busy;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_row_arbiter #(
        .N_REQ(N),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .row_a_in(row_a_in),
        .row_b_in(row_b_in),
        .freeze(freeze),
        .ack(ack),
        .row_A(row_A),
        .row_B(row_B),
        .owner(owner),
        .busy(busy)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // m_showing: a message is within its dwell; m_elapsed counts dwell cycles
    // already served; m_next_first is the producer that gets first look.
    bit           m_showing;
    int           m_elapsed;
    int           m_next_first;
    int           m_owner;
    logic [127:0] m_row_a;
    logic [127:0] m_row_b;
    logic [N-1:0] m_ack;

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) begin
            if (req[(m_next_first + k) % N]) return (m_next_first + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_edge();
        int w;
        bit may_grant;
        m_ack = '0;
        if (!reset_n) begin
            m_showing = 0; m_elapsed = 0; m_next_first = 0; m_owner = N - 1;
            m_row_a = IDLE_A; m_row_b = IDLE_B;
            return;
        end
        may_grant = 0;
        if (!m_showing) begin
            may_grant = 1;
        end else if (!freeze) begin
            if (m_elapsed + 1 >= HOLD) may_grant = 1;  // dwell served
            else m_elapsed++;
        end
        if (may_grant) begin
            w = rr_pick();
            if (w >= 0) begin
                m_showing = 1; m_elapsed = 0; m_owner = w;
                m_next_first = (w + 1) % N;
                m_row_a = row_a_in[w*128 +: 128];
                m_row_b = row_b_in[w*128 +: 128];
                m_ack[w] = 1'b1;
            end else begin
                m_showing = 0;
            end
        end
    endfunction

    function automatic logic [262:0] exp_vec();
        return {m_row_a, m_row_b, m_ack, 2'(m_owner), m_showing};
    endfunction

    wire [262:0] obs_vec = {row_A, row_B, ack, owner, busy};

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rand_text(input int i);
        for (int w = 0; w < 4; w++) begin
            row_a_in[i*128 + w*32 +: 32] = $urandom();
            row_b_in[i*128 + w*32 +: 32] = $urandom();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        freeze  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    function automatic int ack_index(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (a[i]) return i;
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_model c=%0d: got %h expected %h", c, obs_vec, exp_vec());
            end
        end
        n_checks++;
        if ({row_A, row_B, ack, owner, busy} !== {IDLE_A, IDLE_B, 4'b0000, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h/%h ack=%b owner=%0d busy=%b expected idle text ack=0 owner=3 busy=0",
                     row_A, row_B, ack, owner, busy);
        end
    endtask

    task automatic test_single_grant();
        int busy_cycles;
        req = 4'b0100;
        step();
        req = '0;
        n_checks++;
        if (ack !== 4'b0100 || owner !== 2'd2 || row_A !== row_a_in[2*128 +: 128] || row_B !== row_b_in[2*128 +: 128]) begin
            n_fail++;
            $display("FAIL single_grant: ack=%b owner=%0d row_A=%h expected ack=0100 owner=2 row_A=%h",
                     ack, owner, row_A, row_a_in[2*128 +: 128]);
        end
        busy_cycles = 0;
        for (int c = 0; c < 20 && busy; c++) begin
            busy_cycles++;
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model c=%0d: got %h expected %h", c, obs_vec, exp_vec());
            end
        end
        n_checks++;
        if (busy_cycles != HOLD || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_len: got %0d cycles (busy=%b) expected %0d then idle", busy_cycles, busy, HOLD);
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int times[$];
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 20; c++) begin
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_model c=%0d: got %h expected %h", c, obs_vec, exp_vec());
            end
            n_checks++;
            if ((ack & (ack - 4'd1)) !== 4'd0) begin
                n_fail++;
                $display("FAIL rr_onehot c=%0d: got %b expected at most one bit", c, ack);
            end
            if (ack !== 4'd0) begin
                grants.push_back(ack_index(ack));
                times.push_back(c);
            end
        end
        n_checks++;
        if (grants.size() != 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants expected 5", grants.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
                n_checks++;
                if (grants[g] != g % N || times[g] != 1 + g * HOLD) begin
                    n_fail++;
                    $display("FAIL rr_order g=%0d: got producer %0d at cycle %0d expected %0d at cycle %0d",
                             g, grants[g], times[g], g % N, 1 + g * HOLD);
                end
            end
        end
        req = '0;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_freeze();
        int busy_cycles;
        do_reset();
        req = 4'b0010;
        step();
        req = '0;
        busy_cycles = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            busy_cycles++;
            freeze = (c >= 1 && c < 11);
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL freeze_model c=%0d: got %h expected %h", c, obs_vec, exp_vec());
            end
        end
        freeze = 1'b0;
        n_checks++;
        if (busy_cycles != HOLD + 10) begin
            n_fail++;
            $display("FAIL freeze_busy_len: got %0d cycles expected %0d", busy_cycles, HOLD + 10);
        end
        // freeze landing exactly on dwell end: a waiting request must not be granted
        req = 4'b0001;
        step();
        for (int c = 0; c < HOLD - 1; c++) step();
        req    = 4'b0100;
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (ack !== 4'd0 || busy !== 1'b1 || owner !== 2'd0) begin
                n_fail++;
                $display("FAIL freeze_at_end c=%0d: ack=%b busy=%b owner=%0d expected ack=0 busy=1 owner=0", c, ack, busy, owner);
            end
        end
        freeze = 1'b0;
        step();
        n_checks++;
        if (ack !== 4'b0100 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL unfreeze_grant: ack=%b owner=%0d expected ack=0100 owner=2", ack, owner);
        end
        req = '0;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_text_latch();
        logic [127:0] old_text;
        logic [127:0] new_text;
        bit           seen;
        do_reset();
        rand_text(0);
        old_text = row_a_in[127:0];
        req = 4'b0001;
        step();
        new_text = ~old_text;
        row_a_in[127:0] = new_text;
        for (int c = 0; c < HOLD - 1; c++) begin
            step();
            n_checks++;
            if (row_A !== old_text) begin
                n_fail++;
                $display("FAIL text_held c=%0d: got %h expected %h", c, row_A, old_text);
            end
        end
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            step();
            seen = ack[0];
        end
        n_checks++;
        if (!seen || row_A !== new_text) begin
            n_fail++;
            $display("FAIL text_regrant: regrant=%b row_A=%h expected regrant=1 row_A=%h", seen, row_A, new_text);
        end
        req = '0;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 6; c++) step();
        reset_n = 1'b0;
        step();
        n_checks++;
        if ({row_A, row_B, ack, owner, busy} !== {IDLE_A, IDLE_B, 4'b0000, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got %h/%h ack=%b owner=%0d busy=%b expected idle text ack=0 owner=3 busy=0",
                     row_A, row_B, ack, owner, busy);
        end
        reset_n = 1'b1;
        step();
        n_checks++;
        if (ack !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: ack=%b owner=%0d busy=%b expected ack=0001 owner=0 busy=1", ack, owner, busy);
        end
        req = '0;
        for (int c = 0; c < 6; c++) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            freeze  = ($urandom_range(0, 7) == 0);
            reset_n = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 4) == 0) rand_text($urandom_range(0, N - 1));
            step();
            n_checks++;
            if (obs_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model c=%0d: got %h expected %h", c, obs_vec, exp_vec());
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        freeze  = 1'b0;
        for (int i = 0; i < N; i++) rand_text(i);
        @(negedge clk);
        test_reset();
        test_single_grant();
        test_round_robin();
        test_freeze();
        test_text_latch();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
